// File: rtl/uart_tx_buf_pkg.sv
// uart_tx_buf_pkg: shared UART state encodings, data width and baud divider helper
package uart_tx_buf_pkg;
  localparam int UART_DATA_W = 8;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
  function automatic int uart_div(input int freq, input int rate);
    return freq / rate;
  endfunction
endpackage

// File: rtl/uart_tx_buf_if.sv
// uart_tx_buf_if: byte-wide valid/ready handshake into the UART transmitter
import uart_tx_buf_pkg::*;
interface uart_tx_buf_if;
  logic [UART_DATA_W-1:0] i_data;
  logic i_vld;
  logic o_rdy;
  modport master(output i_data, i_vld, input o_rdy);
  modport slave(input i_data, i_vld, output o_rdy);
endinterface

// File: rtl/uart_tx_buf_fifo.sv
// uart_tx_fifo: synchronous FIFO, extra pointer bit distinguishes full from empty
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic wr, rd;
  assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
  assign empty = wp == rp;
  assign dout = mem[rp[AW-1:0]];
  assign wr = push & (!full | pop);
  assign rd = pop & !empty;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk) if (wr) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/uart_tx_buf.sv
// uart_tx_buf: FIFO-buffered 8N1 UART transmitter, 8E1 when UART_TX_PARITY_EN is defined
module uart_tx_buf
  import uart_tx_buf_pkg::*;
#(
  parameter int FREQ  = 50_000_000,
  parameter int RATE  = 2_000_000,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  uart_tx_buf_if.slave bus,
  output logic o_tx,
  output logic o_busy
);
  localparam int DIV = uart_div(FREQ, RATE);
  localparam int CW = $clog2(DIV);
`ifdef UART_TX_PARITY_EN
  localparam state_t AFTER_DATA = ST_PARITY;
`else
  localparam state_t AFTER_DATA = ST_STOP;
`endif
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [UART_DATA_W-1:0] sh, dout;
  logic full, empty, up, pop, push, last, tx_d, busy_q;
  assign last = cnt == CW'(DIV - 1);
  assign push = bus.i_vld & bus.o_rdy;
  assign bus.o_rdy = up & !full;
  assign pop = !empty & (state == ST_IDLE | (state == ST_STOP & last));
  assign o_busy = busy_q | !empty;
  uart_tx_fifo #(.WIDTH(UART_DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(bus.i_data),
    .dout(dout), .full(full), .empty(empty)
  );
  always_ff @(posedge clk) state <= rst ? ST_IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:   nxt = empty ? ST_IDLE : ST_START;
      ST_START:  nxt = last ? ST_DATA : ST_START;
      ST_DATA:   nxt = (last && idx == 3'd7) ? AFTER_DATA : ST_DATA;
`ifdef UART_TX_PARITY_EN
      ST_PARITY: nxt = last ? ST_STOP : ST_PARITY;
`endif
      ST_STOP:   nxt = !last ? ST_STOP : empty ? ST_IDLE : ST_START;
      default:   nxt = ST_IDLE;
    endcase
  end
  // o_tx is registered from the current state, so the line trails the FSM by one cycle
  always_comb begin
`ifdef UART_TX_PARITY_EN
    tx_d = state == ST_START ? 1'b0 : state == ST_DATA ? sh[idx] : state == ST_PARITY ? ^sh : 1'b1;
`else
    tx_d = state == ST_START ? 1'b0 : state == ST_DATA ? sh[idx] : 1'b1;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      o_tx <= 1'b1;
      busy_q <= 1'b0;
      up <= 1'b0;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
    end else begin
      o_tx <= tx_d;
      busy_q <= state != ST_IDLE || nxt != ST_IDLE;
      up <= 1'b1;
      cnt <= (last || state == ST_IDLE) ? '0 : cnt + 1'b1;
      if (state == ST_DATA && last) idx <= idx + 3'd1;
      if (pop) sh <= dout;
    end
  end
endmodule

// File: tb/tb_uart_tx_buf.sv
// tb_uart_tx_buf: directed scoreboard bench; a serial monitor decodes frames against queued bytes
module tb_uart_tx_buf;
  localparam int DIV = 25;
`ifdef UART_TX_PARITY_EN
  localparam int FL = 11 * DIV;
`else
  localparam int FL = 10 * DIV;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic o_tx, o_busy;
  logic last_par = 1'b0;
  int cyc = 0;
  int rst_cnt = 0;
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  int starts[$];

  uart_tx_buf_if bus();
  uart_tx_buf #(.FREQ(50_000_000), .RATE(2_000_000), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .o_tx(o_tx), .o_busy(o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) rst_cnt <= rst_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the accepting edge, acc = that edge number
  task automatic send(input logic [7:0] d, output int acc, output logic stalled);
    logic r;
    bus.i_data = d;
    bus.i_vld = 1'b1;
    stalled = 1'b0;
    acc = -1;
    for (int i = 0; i < 2000 && acc < 0; i++) begin
      r = bus.o_rdy;
      @(posedge clk);
      @(negedge clk);
      if (r) acc = cyc;
      else stalled = 1'b1;
    end
    bus.i_vld = 1'b0;
    chk("accept_in_time", acc >= 0, 1);
    if (acc >= 0) exp_q.push_back(d);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 8 * FL && (exp_q.size() != 0 || o_busy); i++) @(negedge clk);
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_busy", o_busy, 0);
    repeat (DIV) @(negedge clk);
  endtask

  initial begin : mon
    logic [7:0] b, e;
    logic st, sp, par;
    int r0;
    forever begin
      @(negedge clk);
      if (!rst && o_tx === 1'b0) begin
        starts.push_back(cyc);
        r0 = rst_cnt;
        par = 1'b0;
        repeat (DIV / 2) @(negedge clk);
        st = o_tx;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = o_tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (DIV) @(negedge clk);
        par = o_tx;
`endif
        repeat (DIV) @(negedge clk);
        sp = o_tx;
        if (rst_cnt == r0) begin
          chk("start_bit", st, 0);
          chk("stop_bit", sp, 1);
          chk("frame_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rx_byte", b, e);
`ifdef UART_TX_PARITY_EN
            chk("parity_bit", par, ^e);
`endif
          end
          last_par = par;
        end
      end
    end
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n, d, sb, sc, first_stall;
    int accs[6];
    logic stl[6];
    logic stalled;
    bus.i_vld = 1'b0;
    bus.i_data = 8'h00;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_tx", o_tx, 1);
      chk("rst_rdy", bus.o_rdy, 0);
      chk("rst_busy", o_busy, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", bus.o_rdy, 1);
    chk("idle_tx", o_tx, 1);
    chk("idle_busy", o_busy, 0);

    sb = starts.size();
    send(8'hA5, n, stalled);
    chk("a5_no_stall", stalled, 0);
    chk("busy_after_accept", o_busy, 1);
    chk("tx_high_at_accept", o_tx, 1);
    for (int i = 0; i < 2 * FL && o_busy; i++) @(negedge clk);
    chk("busy_drop_edge", cyc, n + 2 + FL);
    chk("start_edge", starts.size() > sb ? starts[sb] : -1, n + 2);
    wait_drain();

    sb = starts.size();
    for (int k = 0; k < 5; k++) send(8'(k), accs[k], stl[k]);
    chk("rdy_low_when_full", bus.o_rdy, 0);
    send(8'h05, accs[5], stl[5]);
    first_stall = -1;
    for (int k = 0; k < 6; k++) if (stl[k] && first_stall < 0) first_stall = k;
    chk("stall_index", first_stall, 5);
    wait_drain();
    chk("burst_frames", starts.size() - sb, 6);
    if (starts.size() >= sb + 6)
      for (int k = 0; k < 5; k++) chk("start_gap", starts[sb + k + 1] - starts[sb + k], FL);
    chk("full_push_accept_edge", starts.size() > sb + 1 ? starts[sb + 1] : -1, accs[5]);

    sb = starts.size();
    send(8'h11, n, stalled);
    send(8'h22, n, stalled);
    send(8'h33, n, stalled);
    for (int i = 0; i < 100 && starts.size() == sb; i++) @(negedge clk);
    chk("mid_started", starts.size(), sb + 1);
    d = starts.size() > sb ? starts[sb] + 4 * DIV + 10 : cyc;
    for (int i = 0; i < FL && cyc < d; i++) @(negedge clk);
    chk("tx_data_bit3", o_tx, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx", o_tx, 1);
    chk("mid_rst_rdy", bus.o_rdy, 0);
    chk("mid_rst_busy", o_busy, 0);
    rst = 1'b0;
    exp_q.delete();
    sc = starts.size();
    repeat (3 * FL) @(negedge clk);
    chk("no_frames_after_rst", starts.size(), sc);
    chk("post_rst_tx", o_tx, 1);
    chk("post_rst_busy", o_busy, 0);

    send(8'h07, n, stalled);
    for (int i = 0; i < 2 * FL && o_busy; i++) @(negedge clk);
    chk("frame_len_07", cyc - n - 2, FL);
    wait_drain();
`ifdef UART_TX_PARITY_EN
    chk("parity_07", last_par, 1);
`endif
    send(8'h03, n, stalled);
    wait_drain();
`ifdef UART_TX_PARITY_EN
    chk("parity_03", last_par, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
